axi4_r_resp_gen: RTL and testbench

Slave-side AXI4 read-data (R channel) response generator. Accepts one read command at a time (ID, burst length, error flag) and a local data-beat stream. Emits a correctly framed R burst with RID, RRESP and RLAST on the final beat. Sits between a slave's internal read datapath and its AXI4 R port, and is the read-direction counterpart of the W-channel logic on the write side.

---
 rtl/axi4_r_resp_gen.sv | 110 +++++++++++
 tb/tb_axi4_r_resp_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_r_resp_gen.sv
// AXI4 slave R-channel response generator: frames one read command into an R burst.
// Optional RUSER passthrough is enabled by defining AXI4_R_RESP_GEN_USER_EN.
module axi4_r_resp_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_err,
  input  logic                  dat_valid,
  output logic                  dat_ready,
  input  logic [DATA_WIDTH-1:0] dat_data,
  input  logic [USER_WIDTH-1:0] dat_user,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic [USER_WIDTH-1:0] ruser,
  output logic                  busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state, state_nxt;
  logic [LEN_WIDTH-1:0]   cnt;
  logic [ID_WIDTH-1:0]    id_q;
  logic                   err_q;
  logic                   slot_free;
  logic                   accept;
  logic                   load;

  assign slot_free = !rvalid || rready;
  assign busy      = (state == BURST) || rvalid;

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    dat_ready = 1'b0;
    accept    = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = aresetn;
        accept    = aresetn && cmd_valid;
        if (accept) state_nxt = BURST;
      end
      BURST: begin
        // Error bursts synthesise their beats and never touch the local stream.
        dat_ready = aresetn && slot_free && !err_q;
        load      = aresetn && slot_free && (err_q || dat_valid);
        if (load && (cnt == '0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state  <= IDLE;
      cnt    <= '0;
      id_q   <= '0;
      err_q  <= 1'b0;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rdata  <= '0;
      rid    <= '0;
      rresp  <= 2'b00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        id_q  <= cmd_id;
        err_q <= cmd_err;
        cnt   <= cmd_len;
      end
      if (load) begin
        if (cnt != '0) cnt <= cnt - LEN_WIDTH'(1);
        rvalid <= 1'b1;
        rdata  <= err_q ? '0 : dat_data;
        rid    <= id_q;
        rresp  <= err_q ? 2'b10 : 2'b00;
        rlast  <= (cnt == '0);
      end else if (rready) begin
        rvalid <= 1'b0;
      end
    end
  end

`ifdef AXI4_R_RESP_GEN_USER_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ruser <= '0;
    end else if (load) begin
      ruser <= err_q ? '0 : dat_user;
    end
  end
`else
  logic [USER_WIDTH-1:0] unused_user;
  assign unused_user = dat_user;
  assign ruser       = '0;
`endif

endmodule

// File: tb/tb_axi4_r_resp_gen.sv
// Directed bench for axi4_r_resp_gen: per-cycle vector table plus max-length and reset sequences.
module tb_axi4_r_resp_gen;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_id;
  logic [7:0]  cmd_len;
  logic        cmd_err;
  logic        dat_valid;
  logic        dat_ready;
  logic [31:0] dat_data;
  logic [0:0]  dat_user;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic [0:0]  ruser;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  axi4_r_resp_gen #(
    .DATA_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(1), .LEN_WIDTH(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_len(cmd_len), .cmd_err(cmd_err),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data), .dat_user(dat_user),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp),
    .rlast(rlast), .ruser(ruser), .busy(busy)
  );

  // One row = inputs held for one cycle and the outputs expected in that cycle.
  typedef struct {
    logic        cv;
    logic [3:0]  cid;
    logic [7:0]  clen;
    logic        cerr;
    logic        dv;
    logic [31:0] dd;
    logic        rr;
    logic        ecr;
    logic        edr;
    logic        erv;
    logic [31:0] erd;
    logic [3:0]  eid;
    logic [1:0]  eresp;
    logic        elast;
    logic        ebusy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic cv, logic [3:0] cid, logic [7:0] clen, logic cerr,
                              logic dv, logic [31:0] dd, logic rr,
                              logic ecr, logic edr, logic erv, logic [31:0] erd,
                              logic [3:0] eid, logic [1:0] eresp, logic elast, logic ebusy);
    vec_t v;
    v.cv = cv; v.cid = cid; v.clen = clen; v.cerr = cerr;
    v.dv = dv; v.dd = dd; v.rr = rr;
    v.ecr = ecr; v.edr = edr; v.erv = erv; v.erd = erd;
    v.eid = eid; v.eresp = eresp; v.elast = elast; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic check(input string name, input logic ok, input string got, input string want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got: %s want: %s", name, got, want);
    end
  endtask

  function automatic string outs();
    return $sformatf("cr=%0b dr=%0b rv=%0b rd=%h id=%0d resp=%0d last=%0b user=%0b busy=%0b",
                     cmd_ready, dat_ready, rvalid, rdata, rid, rresp, rlast, ruser, busy);
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_id = '0; cmd_len = '0; cmd_err = 1'b0;
    dat_valid = 1'b0; dat_data = '0; dat_user = '0; rready = 1'b1;
  endtask

  initial begin
    int beats;
    int nxt;
    int seen;
    logic ok;

    // Single beat, id 3
    vt.push_back(mk(1,3,0,0, 0,32'h0,1,        1,0,0,32'h0,0,0,0,0));
    vt.push_back(mk(0,0,0,0, 1,32'hA5A5A5A5,1, 0,1,0,32'h0,0,0,0,1));
    vt.push_back(mk(0,0,0,0, 0,32'h0,1,        1,0,1,32'hA5A5A5A5,3,0,1,1));
    vt.push_back(mk(0,0,0,0, 0,32'h0,1,        1,0,0,32'h0,0,0,0,0));
    // Four beats, id 5, rready 1,0,0,1 pattern
    vt.push_back(mk(1,5,3,0, 0,32'h0,1, 1,0,0,32'h0,0,0,0,0));
    vt.push_back(mk(0,0,0,0, 1,32'h1,1, 0,1,0,32'h0,0,0,0,1));
    vt.push_back(mk(0,0,0,0, 1,32'h2,0, 0,0,1,32'h1,5,0,0,1));
    vt.push_back(mk(0,0,0,0, 1,32'h2,0, 0,0,1,32'h1,5,0,0,1));
    vt.push_back(mk(0,0,0,0, 1,32'h2,1, 0,1,1,32'h1,5,0,0,1));
    vt.push_back(mk(0,0,0,0, 1,32'h3,0, 0,0,1,32'h2,5,0,0,1));
    vt.push_back(mk(0,0,0,0, 1,32'h3,0, 0,0,1,32'h2,5,0,0,1));
    vt.push_back(mk(0,0,0,0, 1,32'h3,1, 0,1,1,32'h2,5,0,0,1));
    vt.push_back(mk(0,0,0,0, 1,32'h4,1, 0,1,1,32'h3,5,0,0,1));
    vt.push_back(mk(0,0,0,0, 1,32'h5,0, 1,0,1,32'h4,5,0,1,1));
    vt.push_back(mk(0,0,0,0, 0,32'h0,1, 1,0,1,32'h4,5,0,1,1));
    vt.push_back(mk(0,0,0,0, 0,32'h0,1, 1,0,0,32'h0,0,0,0,0));
    // Error burst, id 9, two beats, local data offered throughout
    vt.push_back(mk(1,9,1,1, 1,32'hDEAD,1, 1,0,0,32'h0,0,0,0,0));
    vt.push_back(mk(0,0,0,0, 1,32'hDEAD,1, 0,0,0,32'h0,0,0,0,1));
    vt.push_back(mk(0,0,0,0, 1,32'hDEAD,1, 0,0,1,32'h0,9,2,0,1));
    vt.push_back(mk(0,0,0,0, 1,32'hDEAD,1, 1,0,1,32'h0,9,2,1,1));
    vt.push_back(mk(0,0,0,0, 0,32'h0,1,    1,0,0,32'h0,0,0,0,0));
    // Back-to-back: len1 id1 then len0 id2, one bubble between bursts
    vt.push_back(mk(1,1,1,0, 1,32'h11,1, 1,0,0,32'h0,0,0,0,0));
    vt.push_back(mk(1,2,0,0, 1,32'h11,1, 0,1,0,32'h0,0,0,0,1));
    vt.push_back(mk(1,2,0,0, 1,32'h12,1, 0,1,1,32'h11,1,0,0,1));
    vt.push_back(mk(1,2,0,0, 1,32'h21,1, 1,0,1,32'h12,1,0,1,1));
    vt.push_back(mk(0,0,0,0, 1,32'h21,1, 0,1,0,32'h0,0,0,0,1));
    vt.push_back(mk(0,0,0,0, 0,32'h0,1,  1,0,1,32'h21,2,0,1,1));
    vt.push_back(mk(0,0,0,0, 0,32'h0,1,  1,0,0,32'h0,0,0,0,0));

    // Reset with a command and data offered: nothing may be accepted.
    idle_inputs();
    aresetn   = 1'b0;
    cmd_valid = 1'b1;
    dat_valid = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    check("reset_state",
          !cmd_ready && !dat_ready && !rvalid && rdata == 32'h0 && rid == 4'h0 &&
          rresp == 2'b00 && !rlast && ruser == 1'b0 && !busy,
          outs(), "all zero");
    @(negedge aclk);
    idle_inputs();
    aresetn = 1'b1;

    foreach (vt[i]) begin
      @(negedge aclk);
      cmd_valid = vt[i].cv; cmd_id = vt[i].cid; cmd_len = vt[i].clen; cmd_err = vt[i].cerr;
      dat_valid = vt[i].dv; dat_data = vt[i].dd; rready = vt[i].rr; dat_user = '0;
      #1;
      ok = (cmd_ready == vt[i].ecr) && (dat_ready == vt[i].edr) &&
           (rvalid == vt[i].erv) && (busy == vt[i].ebusy);
      if (vt[i].erv)
        ok = ok && (rdata == vt[i].erd) && (rid == vt[i].eid) && (rresp == vt[i].eresp) &&
             (rlast == vt[i].elast) && (ruser == 1'b0);
      check($sformatf("vec%0d", i), ok, outs(),
            $sformatf("cr=%0b dr=%0b rv=%0b rd=%h id=%0d resp=%0d last=%0b busy=%0b",
                      vt[i].ecr, vt[i].edr, vt[i].erv, vt[i].erd, vt[i].eid,
                      vt[i].eresp, vt[i].elast, vt[i].ebusy));
    end

    // Max length: 256 beats, rlast only on the final one.
    @(negedge aclk);
    idle_inputs();
    cmd_valid = 1'b1; cmd_id = 4'd7; cmd_len = 8'd255;
    beats = 0;
    nxt   = 0;
    for (int cyc = 0; cyc < 600 && beats < 256; cyc++) begin
      @(negedge aclk);
      cmd_valid = 1'b0;
      dat_valid = 1'b1;
      dat_data  = nxt;
      #1;
      if (rvalid) begin
        beats++;
        check($sformatf("max_beat%0d", beats),
              rdata == 32'(beats - 1) && rid == 4'd7 && rresp == 2'b00 && rlast == (beats == 256),
              outs(), $sformatf("rd=%h id=7 resp=0 last=%0b", beats - 1, beats == 256));
      end
      if (dat_ready) nxt++;
    end
    check("max_count", beats == 256, $sformatf("%0d beats", beats), "256 beats");
    @(negedge aclk);
    dat_valid = 1'b0;
    #1;
    check("max_idle", cmd_ready && !rvalid && !busy, outs(), "cr=1 rv=0 busy=0");

    // Reset after the second beat of a len=7 burst.
    @(negedge aclk);
    idle_inputs();
    cmd_valid = 1'b1; cmd_id = 4'd4; cmd_len = 8'd7;
    seen = 0;
    for (int cyc = 0; cyc < 20 && seen < 2; cyc++) begin
      @(negedge aclk);
      cmd_valid = 1'b0;
      dat_valid = 1'b1;
      dat_data  = 32'h4000 + cyc;
      #1;
      if (rvalid) seen++;
    end
    check("rst_mid_reach", seen == 2, $sformatf("%0d beats", seen), "2 beats");
    aresetn = 1'b0;
    #1;
    check("rst_mid_gating", !cmd_ready && !dat_ready, outs(), "cr=0 dr=0");
    @(negedge aclk);
    aresetn   = 1'b1;
    dat_valid = 1'b0;
    #1;
    check("rst_mid_after", cmd_ready && !rvalid && !rlast && rdata == 32'h0 && !busy,
          outs(), "cr=1 rv=0 last=0 rd=0 busy=0");
    cmd_valid = 1'b1; cmd_id = 4'd6; cmd_len = 8'd0;
    @(negedge aclk);
    cmd_valid = 1'b0;
    dat_valid = 1'b1;
    dat_data  = 32'h66;
    #1;
    check("rst_new_dready", dat_ready && !cmd_ready, outs(), "dr=1 cr=0");
    @(negedge aclk);
    dat_valid = 1'b0;
    #1;
    check("rst_new_beat", rvalid && rdata == 32'h66 && rid == 4'd6 && rresp == 2'b00 && rlast,
          outs(), "rv=1 rd=66 id=6 resp=0 last=1");
    @(negedge aclk);
    #1;
    check("rst_new_done", cmd_ready && !rvalid && !busy, outs(), "cr=1 rv=0 busy=0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
